pll_reset_sequencer: RTL and testbench

Reset and lock controller for the 50 MHz-referenced PLL, which produces two 100 MHz outputs with 0 ps and 3000 ps phase. The block holds the PLL in reset for a fixed interval, waits for `locked` with a timeout, and retries a bounded number of times. It qualifies lock as stable before releasing the downstream system reset, and re-sequences on lock loss or a software request. It runs on the reference clock, so it stays alive while the PLL outputs are absent.

---
 rtl/pll_reset_sequencer_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 109 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and widths for the PLL reset/lock sequencer.
// Holds the FSM state encoding and a saturating-increment helper for the status counters.
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_t;

  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-low reset.
// Used to bring the asynchronous PLL lock indication into the reference clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the reference clock: timed PLL reset, lock wait with
// bounded retries, lock qualification, and downstream reset release.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 500,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 16
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               soft_reset_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic [STATE_W-1:0] state,
  output logic [2:0]         retry_count,
  output logic [LOSS_W-1:0]  loss_count,
  output logic               fault
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  pll_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_clr;
  logic [2:0]        retry_d;
  logic [LOSS_W-1:0] loss_d;
  logic              locked_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_count;
    loss_d  = loss_count;

    unique case (state_q)
      RESET_PLL: if (cnt == HOLD_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_d = retry_count + 3'd1;
          state_d = (retry_d == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          loss_d  = sat_inc(loss_count);
          state_d = RESET_PLL;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RESET_PLL;
    endcase

    // Software request overrides any transition but keeps a coincident loss count.
    if (soft_reset_req) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end

    cnt_clr = (state_d != state_q) || soft_reset_req;
  end

  // Outputs decode the next state so they move on the same edge as state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt         <= '0;
      retry_count <= '0;
      loss_count  <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt         <= cnt_clr ? '0 : cnt + 1'b1;
      retry_count <= retry_d;
      loss_count  <= loss_d;
      pll_rst     <= (state_d == RESET_PLL) || (state_d == FAULT);
      sys_rst_n   <= (state_d == RUN);
      fault       <= (state_d == FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small timing parameters.
// Expected output values are queued with their due cycle and compared at the falling edge.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 8;
  localparam int RETRIES = 2;

  logic               refclk = 1'b0;
  logic               rst_n = 1'b0;
  logic               locked = 1'b0;
  logic               soft_reset_req = 1'b0;
  logic               pll_rst;
  logic               sys_rst_n;
  logic [STATE_W-1:0] state;
  logic [2:0]         retry_count;
  logic [LOSS_W-1:0]  loss_count;
  logic               fault;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE),
    .MAX_RETRIES         (RETRIES),
    .CNT_W               (16)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .locked         (locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_rst_n      (sys_rst_n),
    .state          (state),
    .retry_count    (retry_count),
    .loss_count     (loss_count),
    .fault          (fault)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef enum int {OBS_STATE, OBS_PLL_RST, OBS_SYS_RST_N, OBS_FAULT, OBS_RETRY, OBS_LOSS} obs_t;
  typedef struct {
    int         due;
    obs_t       sel;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   exp_loss  = 0;

  function automatic logic [7:0] observe(input obs_t s);
    case (s)
      OBS_STATE:     return 8'(state);
      OBS_PLL_RST:   return 8'(pll_rst);
      OBS_SYS_RST_N: return 8'(sys_rst_n);
      OBS_FAULT:     return 8'(fault);
      OBS_RETRY:     return 8'(retry_count);
      default:       return loss_count;
    endcase
  endfunction

  task automatic expect_at(input int due, input obs_t sel, input logic [7:0] val, input string name);
    exp_t e;
    e.due  = due;
    e.sel  = sel;
    e.exp  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Advance one cycle and score every queued expectation that has come due.
  task automatic score_step();
    exp_t       e;
    logic [7:0] got;
    @(negedge refclk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      got = observe(e.sel);
      total_cnt++;
      if (got !== e.exp || e.due != cyc)
        $display("FAIL %s @cycle %0d (due %0d): got %0h expected %0h", e.name, cyc, e.due, got, e.exp);
      else
        pass_cnt++;
    end
  endtask

  task automatic run_until(input int target);
    while (cyc < target) score_step();
  endtask

  task automatic wait_state(input pll_seq_state_t st, input int budget, input string name);
    int n = 0;
    while (state !== st && n < budget) begin
      score_step();
      n++;
    end
    total_cnt++;
    if (state !== st)
      $display("FAIL %s: state %0d, expected %0d within %0d cycles", name, state, st, budget);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    locked = 1'b0;
    run_until(cyc + 3);
    total_cnt += 6;
    if (state !== 3'd0)       $display("FAIL reset_state: got %0d expected 0", state);       else pass_cnt++;
    if (pll_rst !== 1'b1)     $display("FAIL reset_pll_rst: got %b expected 1", pll_rst);    else pass_cnt++;
    if (sys_rst_n !== 1'b0)   $display("FAIL reset_sys_rst_n: got %b expected 0", sys_rst_n); else pass_cnt++;
    if (fault !== 1'b0)       $display("FAIL reset_fault: got %b expected 0", fault);        else pass_cnt++;
    if (retry_count !== 3'd0) $display("FAIL reset_retry: got %0d expected 0", retry_count); else pass_cnt++;
    if (loss_count !== 8'd0)  $display("FAIL reset_loss: got %0d expected 0", loss_count);   else pass_cnt++;
  endtask

  task automatic test_lock_acquire();
    int b;
    rst_n = 1'b1;
    b = cyc;
    expect_at(b + 3,  OBS_PLL_RST,   1, "acq_pll_rst_held");
    expect_at(b + 4,  OBS_PLL_RST,   0, "acq_pll_rst_fall");
    expect_at(b + 4,  OBS_STATE,     1, "acq_wait_lock");
    expect_at(b + 9,  OBS_STATE,     1, "acq_sync_delay");
    expect_at(b + 10, OBS_STATE,     2, "acq_stabilize");
    expect_at(b + 17, OBS_SYS_RST_N, 0, "acq_sys_held");
    expect_at(b + 18, OBS_SYS_RST_N, 1, "acq_sys_release");
    expect_at(b + 18, OBS_STATE,     3, "acq_run");
    expect_at(b + 18, OBS_RETRY,     0, "acq_retry");
    run_until(b + 7);
    locked = 1'b1;
    run_until(b + 18);
  endtask

  task automatic test_lock_loss();
    int b = cyc;
    locked = 1'b0;
    exp_loss++;
    expect_at(b + 2, OBS_SYS_RST_N, 1, "loss_sys_held");
    expect_at(b + 3, OBS_SYS_RST_N, 0, "loss_sys_fall");
    expect_at(b + 3, OBS_PLL_RST,   1, "loss_pll_rst");
    expect_at(b + 3, OBS_STATE,     0, "loss_state");
    expect_at(b + 3, OBS_LOSS,      8'(exp_loss), "loss_count");
    run_until(b + 3);
  endtask

  task automatic test_soft_reset_in_run();
    int b;
    locked = 1'b1;
    wait_state(RUN, 60, "soft_reach_run");
    b = cyc;
    locked = 1'b0;
    exp_loss++;
    expect_at(b + 2, OBS_STATE,     3, "soft_still_run");
    expect_at(b + 3, OBS_STATE,     0, "soft_state");
    expect_at(b + 3, OBS_LOSS,      8'(exp_loss), "soft_loss");
    expect_at(b + 3, OBS_SYS_RST_N, 0, "soft_sys");
    expect_at(b + 3, OBS_PLL_RST,   1, "soft_pll_rst");
    run_until(b + 2);
    soft_reset_req = 1'b1;
    run_until(b + 3);
    soft_reset_req = 1'b0;
  endtask

  task automatic test_loss_saturation();
    int t;
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      wait_state(RUN, 60, "sat_reach_run");
      locked = 1'b0;
      wait_state(RESET_PLL, 10, "sat_reach_reset");
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      if (i == 0) begin
        total_cnt++;
        if (loss_count !== 8'(exp_loss))
          $display("FAIL sat_first_inc: got %0d expected %0d", loss_count, exp_loss);
        else
          pass_cnt++;
      end
    end
    t = cyc + 1;
    expect_at(t, OBS_LOSS, 8'(exp_loss), "sat_loss_255");
    run_until(t);
  endtask

  task automatic test_retry_fault();
    int b;
    rst_n  = 1'b0;
    locked = 1'b0;
    run_until(cyc + 2);
    rst_n = 1'b1;
    b = cyc;
    expect_at(b + 1,  OBS_LOSS,    0, "flt_loss_cleared");
    expect_at(b + 3,  OBS_PLL_RST, 1, "flt_pulse1_held");
    expect_at(b + 4,  OBS_PLL_RST, 0, "flt_pulse1_end");
    expect_at(b + 4,  OBS_STATE,   1, "flt_wait1");
    expect_at(b + 23, OBS_STATE,   1, "flt_wait1_last");
    expect_at(b + 24, OBS_STATE,   0, "flt_retry1_state");
    expect_at(b + 24, OBS_RETRY,   1, "flt_retry1");
    expect_at(b + 24, OBS_PLL_RST, 1, "flt_pulse2_start");
    expect_at(b + 27, OBS_PLL_RST, 1, "flt_pulse2_held");
    expect_at(b + 28, OBS_PLL_RST, 0, "flt_pulse2_end");
    expect_at(b + 47, OBS_STATE,   1, "flt_wait2_last");
    expect_at(b + 48, OBS_STATE,   4, "flt_state");
    expect_at(b + 48, OBS_FAULT,   1, "flt_fault");
    expect_at(b + 48, OBS_RETRY,   2, "flt_retry2");
    expect_at(b + 48, OBS_PLL_RST, 1, "flt_pll_rst");
    expect_at(b + 60, OBS_STATE,   4, "flt_sticky");
    expect_at(b + 61, OBS_STATE,   0, "flt_soft_state");
    expect_at(b + 61, OBS_RETRY,   0, "flt_soft_retry");
    expect_at(b + 61, OBS_FAULT,   0, "flt_soft_fault");
    run_until(b + 60);
    soft_reset_req = 1'b1;
    run_until(b + 61);
    soft_reset_req = 1'b0;
  endtask

  task automatic test_stabilize_glitch();
    int b = cyc;
    expect_at(b + 4,  OBS_STATE,     1, "gl_wait_lock");
    expect_at(b + 6,  OBS_STATE,     1, "gl_sync_delay");
    expect_at(b + 7,  OBS_STATE,     2, "gl_stabilize");
    expect_at(b + 11, OBS_STATE,     2, "gl_stab_5th");
    expect_at(b + 12, OBS_STATE,     1, "gl_back_to_wait");
    expect_at(b + 12, OBS_SYS_RST_N, 0, "gl_sys_low");
    expect_at(b + 13, OBS_STATE,     2, "gl_restabilize");
    expect_at(b + 20, OBS_STATE,     2, "gl_stab_not_done");
    expect_at(b + 20, OBS_SYS_RST_N, 0, "gl_sys_still_low");
    expect_at(b + 21, OBS_STATE,     3, "gl_run");
    expect_at(b + 21, OBS_SYS_RST_N, 1, "gl_sys_release");
    run_until(b + 4);
    locked = 1'b1;
    run_until(b + 9);
    locked = 1'b0;
    run_until(b + 10);
    locked = 1'b1;
    run_until(b + 21);
  endtask

  task automatic test_mid_reset();
    int w;
    int t;
    locked = 1'b0;
    wait_state(WAIT_LOCK, 20, "mid_reach_wait");
    w = cyc;
    expect_at(w + 19, OBS_STATE,   1, "mid_wait_last");
    expect_at(w + 20, OBS_STATE,   0, "mid_timeout_state");
    expect_at(w + 20, OBS_RETRY,   1, "mid_timeout_retry");
    expect_at(w + 20, OBS_PLL_RST, 1, "mid_timeout_pll_rst");
    run_until(w + 20);
    wait_state(WAIT_LOCK, 10, "mid_reach_wait2");
    t = cyc + 3;
    expect_at(t, OBS_RETRY, 1, "mid_retry_before");
    expect_at(t, OBS_LOSS,  1, "mid_loss_before");
    run_until(t);
    rst_n = 1'b0;
    t = cyc + 1;
    expect_at(t, OBS_STATE,     0, "mid_rst_state");
    expect_at(t, OBS_PLL_RST,   1, "mid_rst_pll_rst");
    expect_at(t, OBS_SYS_RST_N, 0, "mid_rst_sys");
    expect_at(t, OBS_FAULT,     0, "mid_rst_fault");
    expect_at(t, OBS_RETRY,     0, "mid_rst_retry");
    expect_at(t, OBS_LOSS,      0, "mid_rst_loss");
    run_until(t + 1);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_acquire();
    test_lock_loss();
    test_soft_reset_in_run();
    test_loss_saturation();
    test_retry_fault();
    test_stabilize_glitch();
    test_mid_reset();
    run_until(cyc + 2);
    total_cnt++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    else
      pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
